// File: rtl/counter_sequence_monitor.sv
// counter_sequence_monitor: checks an upstream binary/Gray counter stream, decodes its position, reports lock, errors and wrap
// Optional macro SEGMENT_DISPLAY_EN builds the seven-segment decoder; without it Segments is held blank.
module counter_sequence_monitor #(
    parameter int LOCK_COUNT = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Control,
    input  logic [2:0] Counter,
    input  logic       Flag,
    output logic [2:0] Binary,
    output logic [6:0] Segments,
    output logic       Locked,
    output logic       ErrorPulse,
    output logic [7:0] ErrorCount,
    output logic       Wrap
);
    localparam logic [1:0] IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2;
    localparam logic [3:0] LAST = 4'(LOCK_COUNT - 1);
    logic [1:0] state;
    logic [3:0] acq_count;
    logic [2:0] prev_counter, prev_index, nxt_index, expected, next_binary;
    logic       prev_control, correct;
    // Successor of the previous sample in the mode it was produced under, and decode of the current sample
    always_comb begin
        prev_index  = prev_control ? {prev_counter[2], ^prev_counter[2:1], ^prev_counter} : prev_counter;
        nxt_index   = prev_index + 3'd1;
        expected    = prev_control ? nxt_index ^ (nxt_index >> 1) : nxt_index;
        correct     = (Counter == expected) && (Flag == ^Counter);
        next_binary = prev_control ? {Counter[2], ^Counter[2:1], ^Counter} : Counter;
    end
    assign Locked = state == LOCKED;
    // Sample history, decoded position and the IDLE/ACQUIRE/LOCKED tracker
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            acq_count    <= 4'd0;
            prev_counter <= 3'd0;
            prev_control <= 1'b0;
            Binary       <= 3'd0;
            ErrorPulse   <= 1'b0;
            ErrorCount   <= 8'd0;
            Wrap         <= 1'b0;
        end else begin
            prev_counter <= Counter;
            prev_control <= Control;
            Binary       <= next_binary;
            ErrorPulse   <= 1'b0;
            Wrap         <= 1'b0;
            case (state)
                IDLE: state <= ACQUIRE;
                ACQUIRE: begin
                    if (!correct) acq_count <= 4'd0;
                    else if (acq_count == LAST) begin
                        state     <= LOCKED;
                        acq_count <= 4'd0;
                    end else acq_count <= acq_count + 4'd1;
                end
                LOCKED: begin
                    if (!correct) begin
                        ErrorPulse <= 1'b1;
                        ErrorCount <= ErrorCount + 8'(ErrorCount != 8'hff);
                        state      <= ACQUIRE;
                        acq_count  <= 4'd0;
                    end else Wrap <= expected == 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SEGMENT_DISPLAY_EN
    logic [6:0] seg_next;
    // Active-low {g,f,e,d,c,b,a} digit for the position being registered into Binary
    always_comb begin
        case (next_binary)
            3'd0:    seg_next = 7'b1000000;
            3'd1:    seg_next = 7'b1111001;
            3'd2:    seg_next = 7'b0100100;
            3'd3:    seg_next = 7'b0110000;
            3'd4:    seg_next = 7'b0011001;
            3'd5:    seg_next = 7'b0010010;
            3'd6:    seg_next = 7'b0000010;
            default: seg_next = 7'b1111000;
        endcase
    end
    // Segments tracks Binary in lockstep and blanks on reset
    always_ff @(posedge Clock) begin
        if (Reset) Segments <= 7'b1111111;
        else Segments <= seg_next;
    end
`else
    assign Segments = 7'b1111111;
`endif
endmodule
